pre_id_bundle: RTL and testbench

PRE_ID_BUNDLE -- requirements
Module: pre_id_bundle

---
 rtl/pre_id_bundle.sv | 238 +++++++++++++++++++++++
 tb/tb_pre_id_bundle.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/pre_id_bundle.sv
// -----------------------------------------------------------------------------
// pre_id_bundle
// Pre-decode stage for a MIPS-style fetch bundle. Each lane is classified
// as a control-transfer instruction (RET / CALL / PC-relative branch) or
// NUL, and its predicted target is computed. A return-address stack (RAS)
// provides RET targets. The first CTI lane of an accepted bundle may push
// (JAL) or pop (JR $31) the RAS. The result is held in a single
// valid/ready register stage.
//
// Parameters
//   LANES       instructions per bundle (1..4)
//   RAS_DEPTH   return-address-stack entries (power of 2, >= 2)
//
// Ports
//   clk            rising-edge clock
//   rst            synchronous active-high reset
//   flush          drop the registered bundle; RAS is not touched
//   in_valid       upstream offers a bundle
//   in_ready       stage can take a bundle this cycle
//   in_pc          PC of lane 0 (lane i = in_pc + 4*i)
//   in_inst        lane i instruction at [32i+31:32i]
//   in_lane_vld    per-lane valid
//   out_valid      registered bundle present
//   out_ready      downstream takes the registered bundle
//   out_pc         registered in_pc
//   out_type       per-lane type (NUL=00, RET=01, CALL=10, PCR=11)
//   out_target     per-lane predicted target (0 for NUL)
//   out_has_cti    any lane is a CTI
//   out_first_cti  lowest CTI lane index (0 when none)
//   ras_count      number of valid RAS entries
// -----------------------------------------------------------------------------
module pre_id_bundle #(
    parameter int LANES     = 2,
    parameter int RAS_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          flush,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [31:0]                   in_pc,
    input  logic [32*LANES-1:0]           in_inst,
    input  logic [LANES-1:0]              in_lane_vld,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [31:0]                   out_pc,
    output logic [2*LANES-1:0]            out_type,
    output logic [32*LANES-1:0]           out_target,
    output logic                          out_has_cti,
    output logic [1:0]                    out_first_cti,
    output logic [$clog2(RAS_DEPTH):0]    ras_count
);

    localparam int PW = $clog2(RAS_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] C_RAS_FULL = CW'(RAS_DEPTH);

    localparam logic [1:0] T_NUL  = 2'b00;
    localparam logic [1:0] T_RET  = 2'b01;
    localparam logic [1:0] T_CALL = 2'b10;
    localparam logic [1:0] T_PCR  = 2'b11;

    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_REGIMM  = 6'h01;
    localparam logic [5:0] OP_J       = 6'h02;
    localparam logic [5:0] OP_JAL     = 6'h03;
    localparam logic [5:0] OP_BEQ     = 6'h04;
    localparam logic [5:0] OP_BNE     = 6'h05;
    localparam logic [5:0] OP_BLEZ    = 6'h06;
    localparam logic [5:0] OP_BGTZ    = 6'h07;
    localparam logic [5:0] FN_JR      = 6'h08;

    // Lane classification from opcode/rt/funct; invalid lanes are NUL.
    function automatic logic [1:0] f_classify(input logic [31:0] inst, input logic vld);
        logic [1:0] t;
        t = T_NUL;
        if (vld) begin
            case (inst[31:26])
                OP_SPECIAL: begin
                    // JALR deliberately stays NUL: its target is not predictable here.
                    if (inst[5:0] == FN_JR) t = T_RET;
                    else                    t = T_NUL;
                end
                OP_J, OP_JAL:                    t = T_CALL;
                OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ: t = T_PCR;
                OP_REGIMM: begin
                    case (inst[20:16])
                        5'h00, 5'h01, 5'h10, 5'h11: t = T_PCR;
                        default:                    t = T_NUL;
                    endcase
                end
                default: t = T_NUL;
            endcase
        end else begin
            t = T_NUL;
        end
        return t;
    endfunction

    // Predicted target for one lane given its type.
    function automatic logic [31:0] f_target(input logic [1:0] t, input logic [31:0] inst,
                                             input logic [31:0] pc, input logic [31:0] ras_top);
        logic [31:0] pc4;
        logic [31:0] tgt;
        pc4 = pc + 32'd4;
        case (t)
            T_CALL:  tgt = {pc4[31:28], inst[25:0], 2'b00};
            T_PCR:   tgt = pc4 + {{14{inst[15]}}, inst[15:0], 2'b00};
            T_RET:   tgt = ras_top;
            default: tgt = 32'h0000_0000;
        endcase
        return tgt;
    endfunction

    logic                  r_out_valid;
    logic [31:0]           r_out_pc;
    logic [2*LANES-1:0]    r_out_type;
    logic [32*LANES-1:0]   r_out_target;
    logic                  r_out_has_cti;
    logic [1:0]            r_out_first_cti;
    logic [31:0]           r_ras_mem [RAS_DEPTH];
    logic [PW-1:0]         r_ras_ptr;      // next free slot; top is r_ras_ptr-1
    logic [CW-1:0]         r_ras_count;

    logic                  w_in_ready;
    logic                  w_accept;
    logic [31:0]           w_ras_top;
    logic [2*LANES-1:0]    w_type;
    logic [32*LANES-1:0]   w_target;
    logic                  w_has_cti;
    logic [1:0]            w_first_idx;
    logic [31:0]           w_first_inst;
    logic [31:0]           w_first_pc;
    logic                  w_push;
    logic                  w_pop;
    logic [31:0]           w_push_addr;

    // Handshake: flush blocks any accept in the cycle it is asserted.
    always_comb begin
        w_in_ready = ~flush & (~r_out_valid | out_ready);
        w_accept   = in_valid & w_in_ready;
    end

    // RAS top as seen before this cycle's push/pop; empty stack reads 0.
    always_comb begin
        if (r_ras_count != {CW{1'b0}}) begin
            w_ras_top = r_ras_mem[r_ras_ptr - {{(PW-1){1'b0}}, 1'b1}];
        end else begin
            w_ras_top = 32'h0000_0000;
        end
    end

    // Per-lane decode, first-CTI search and the RAS action of that lane.
    always_comb begin
        logic [31:0] pc_i;
        logic [31:0] inst_i;
        logic [1:0]  t_i;
        w_type       = '0;
        w_target     = '0;
        w_has_cti    = 1'b0;
        w_first_idx  = 2'b00;
        w_first_inst = 32'h0000_0000;
        w_first_pc   = 32'h0000_0000;
        for (int i = 0; i < LANES; i++) begin
            pc_i   = in_pc + 32'(4 * i);
            inst_i = in_inst[32*i +: 32];
            t_i    = f_classify(inst_i, in_lane_vld[i]);
            w_type[2*i +: 2]    = t_i;
            w_target[32*i +: 32] = f_target(t_i, inst_i, pc_i, w_ras_top);
            if (!w_has_cti && (t_i != T_NUL)) begin
                w_has_cti    = 1'b1;
                w_first_idx  = 2'(i);
                w_first_inst = inst_i;
                w_first_pc   = pc_i;
            end else begin
                w_has_cti    = w_has_cti;
            end
        end
        // Only the first CTI lane may touch the RAS.
        w_push      = w_has_cti && (w_first_inst[31:26] == OP_JAL);
        w_pop       = w_has_cti && (w_first_inst[31:26] == OP_SPECIAL) &&
                      (w_first_inst[5:0] == FN_JR) && (w_first_inst[25:21] == 5'd31);
        w_push_addr = w_first_pc + 32'd8;
    end

    // Output register stage: reset > flush > accept > drain > hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid     <= 1'b0;
            r_out_pc        <= 32'h0000_0000;
            r_out_type      <= '0;
            r_out_target    <= '0;
            r_out_has_cti   <= 1'b0;
            r_out_first_cti <= 2'b00;
        end else if (flush) begin
            r_out_valid     <= 1'b0;
        end else if (w_accept) begin
            r_out_valid     <= 1'b1;
            r_out_pc        <= in_pc;
            r_out_type      <= w_type;
            r_out_target    <= w_target;
            r_out_has_cti   <= w_has_cti;
            r_out_first_cti <= w_first_idx;
        end else if (out_ready) begin
            r_out_valid     <= 1'b0;
        end
    end

    // Return-address stack: circular buffer, push on full overwrites oldest.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ras_ptr   <= '0;
            r_ras_count <= '0;
            for (int k = 0; k < RAS_DEPTH; k++) begin
                r_ras_mem[k] <= 32'h0000_0000;
            end
        end else if (w_accept && w_push) begin
            r_ras_mem[r_ras_ptr] <= w_push_addr;
            r_ras_ptr            <= r_ras_ptr + {{(PW-1){1'b0}}, 1'b1};
            if (r_ras_count != C_RAS_FULL) begin
                r_ras_count <= r_ras_count + {{(CW-1){1'b0}}, 1'b1};
            end
        end else if (w_accept && w_pop && (r_ras_count != {CW{1'b0}})) begin
            r_ras_ptr   <= r_ras_ptr - {{(PW-1){1'b0}}, 1'b1};
            r_ras_count <= r_ras_count - {{(CW-1){1'b0}}, 1'b1};
        end
    end

    assign in_ready      = w_in_ready;
    assign out_valid     = r_out_valid;
    assign out_pc        = r_out_pc;
    assign out_type      = r_out_type;
    assign out_target    = r_out_target;
    assign out_has_cti   = r_out_has_cti;
    assign out_first_cti = r_out_first_cti;
    assign ras_count     = r_ras_count;

endmodule

// File: tb/tb_pre_id_bundle.sv
// -----------------------------------------------------------------------------
// tb_pre_id_bundle
// Directed bench for pre_id_bundle (LANES=2, RAS_DEPTH=8). Inputs change
// 1 time unit after a rising edge; outputs are compared at that point too.
// -----------------------------------------------------------------------------
module tb_pre_id_bundle;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_pc;
    logic [63:0] in_inst;
    logic [1:0]  in_lane_vld;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [3:0]  out_type;
    logic [63:0] out_target;
    logic        out_has_cti;
    logic [1:0]  out_first_cti;
    logic [3:0]  ras_count;

    int checks;
    int errors;

    localparam logic [31:0] JR31 = 32'h03E0_0008;
    localparam logic [31:0] NOP  = 32'h0000_0000;

    pre_id_bundle #(.LANES(2), .RAS_DEPTH(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_pc        (in_pc),
        .in_inst      (in_inst),
        .in_lane_vld  (in_lane_vld),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_pc       (out_pc),
        .out_type     (out_type),
        .out_target   (out_target),
        .out_has_cti  (out_has_cti),
        .out_first_cti(out_first_cti),
        .ras_count    (ras_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] jal(input logic [25:0] idx);
        return {6'h03, idx};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic offer(input logic [31:0] pc, input logic [31:0] i1, input logic [31:0] i0,
                         input logic [1:0] vld);
        in_valid    = 1'b1;
        in_pc       = pc;
        in_inst     = {i1, i0};
        in_lane_vld = vld;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_pc = 32'h0; in_inst = 64'h0; in_lane_vld = 2'b00;
        tick();
        tick();
        rst = 1'b0;
        #1;
        chk("rst_valid",  64'(out_valid), 64'd0);
        chk("rst_pc",     64'(out_pc), 64'd0);
        chk("rst_type",   64'(out_type), 64'd0);
        chk("rst_target", out_target, 64'd0);
        chk("rst_hascti", 64'(out_has_cti), 64'd0);
        chk("rst_first",  64'(out_first_cti), 64'd0);
        chk("rst_count",  64'(ras_count), 64'd0);
        chk("rst_ready",  64'(in_ready), 64'd1);

        // JAL at 0x1000, idx 0x400 -> target 0x1000, push 0x1008
        offer(32'h1000, NOP, jal(26'h0000400), 2'b01);
        tick();
        chk("jal_valid",  64'(out_valid), 64'd1);
        chk("jal_type",   64'(out_type), 64'h2);
        chk("jal_target", out_target, 64'h0000_0000_0000_1000);
        chk("jal_count",  64'(ras_count), 64'd1);
        chk("jal_first",  64'(out_first_cti), 64'd0);

        // JR $31 pops 0x1008, then a second JR finds the stack empty
        offer(32'h1100, NOP, JR31, 2'b01);
        tick();
        chk("jr_type",   64'(out_type), 64'h1);
        chk("jr_target", out_target, 64'h0000_0000_0000_1008);
        chk("jr_count",  64'(ras_count), 64'd0);
        tick();
        chk("jr2_target", out_target, 64'd0);
        chk("jr2_count",  64'(ras_count), 64'd0);

        // BNE in lane 1 with offset -1: 0x2004 + 4 - 4
        offer(32'h2000, 32'h1400_FFFF, NOP, 2'b11);
        tick();
        chk("bne_type",   64'(out_type), 64'hC);
        chk("bne_target", out_target, 64'h0000_2004_0000_0000);
        chk("bne_first",  64'(out_first_cti), 64'd1);
        chk("bne_hascti", 64'(out_has_cti), 64'd1);

        // 9 pushes into an 8-deep stack, then 8 LIFO pops and one empty pop
        for (int k = 1; k <= 9; k++) begin
            offer(32'(k * 256), NOP, jal(26'h0), 2'b01);
            tick();
        end
        chk("full_count", 64'(ras_count), 64'd8);
        for (int k = 9; k >= 2; k--) begin
            offer(32'h6000, NOP, JR31, 2'b01);
            tick();
            chk($sformatf("pop%0d_target", k), out_target, 64'(k * 256 + 8));
        end
        chk("empty_count", 64'(ras_count), 64'd0);
        tick();
        chk("pop_empty_target", out_target, 64'd0);
        chk("pop_empty_count",  64'(ras_count), 64'd0);

        // Backpressure: hold 0x3000 for 3 cycles while 0x3100 (JAL) waits
        offer(32'h3000, NOP, jal(26'h0), 2'b01);
        tick();
        chk("bp_load_count", 64'(ras_count), 64'd1);
        out_ready = 1'b0;
        offer(32'h3100, NOP, jal(26'h0), 2'b01);
        #1;
        chk("bp_ready0", 64'(in_ready), 64'd0);
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("bp_valid", 64'(out_valid), 64'd1);
            chk("bp_pc",    64'(out_pc), 64'h3000);
            chk("bp_type",  64'(out_type), 64'h2);
            chk("bp_count", 64'(ras_count), 64'd1);
            chk("bp_ready", 64'(in_ready), 64'd0);
        end
        out_ready = 1'b1;
        #1;
        chk("bp_ready1", 64'(in_ready), 64'd1);
        tick();
        chk("bp_next_pc",    64'(out_pc), 64'h3100);
        chk("bp_next_count", 64'(ras_count), 64'd2);
        offer(32'h3200, NOP, JR31, 2'b01);
        tick();
        chk("bp_pop_pc",     64'(out_pc), 64'h3200);
        chk("bp_pop_target", out_target, 64'h0000_0000_0000_3108);
        chk("bp_pop_count",  64'(ras_count), 64'd1);

        // BEQ lane0 + JAL lane1: BEQ is the first CTI, so no push
        offer(32'h4000, jal(26'h10), 32'h1000_0003, 2'b11);
        tick();
        chk("mix_type",   64'(out_type), 64'hB);
        chk("mix_target", out_target, 64'h0000_0040_0000_4010);
        chk("mix_first",  64'(out_first_cti), 64'd0);
        chk("mix_count",  64'(ras_count), 64'd1);

        // Flush with a JAL offered: no accept, no push, valid drops
        flush = 1'b1;
        offer(32'h5000, NOP, jal(26'h0), 2'b01);
        #1;
        chk("flush_ready", 64'(in_ready), 64'd0);
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        chk("flush_valid", 64'(out_valid), 64'd0);
        chk("flush_count", 64'(ras_count), 64'd1);
        #1;
        chk("flush_after_ready", 64'(in_ready), 64'd1);

        // Reset mid-operation clears the held bundle and the RAS
        offer(32'h7000, NOP, jal(26'h0), 2'b01);
        tick();
        in_valid = 1'b0;
        chk("pre_rst_count", 64'(ras_count), 64'd2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_count", 64'(ras_count), 64'd0);
        chk("mid_rst_pc",    64'(out_pc), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
